// File: rtl/mcb_arb_pkg.sv
// Shared types and constants for the MCB command-port arbiter.
// State enum, owner encoding, MCB instruction codes, length clamp.
package mcb_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_CMD  = 3'd2,
        RD_CMD  = 3'd3,
        RD_DATA = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_WR = 1'b0,
        OWN_RD = 1'b1
    } owner_e;

    localparam logic [2:0] INSTR_WR = 3'b000;
    localparam logic [2:0] INSTR_RD = 3'b001;

    // Clamp a burst length to 1..max_len and return it minus one.
    function automatic logic [5:0] clamp_bl(
        input int unsigned len,
        input int unsigned max_len
    );
        int unsigned c;
        c = len;
        if (c < 1) c = 1;
        if (c > max_len) c = max_len;
        return 6'(c - 1);
    endfunction

endpackage

// File: rtl/mcb_arb_wdog.sv
// Data-phase watchdog: counts cycles while enabled, held at 0 by clr.
// Ports: clk, rst_n (sync, active-low), clr_i, en_i, expire_o.
module mcb_arb_wdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != CW'(TIMEOUT))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Fires in the TIMEOUT-th cycle of the data phase, so the state
    // leaves exactly TIMEOUT cycles after entry.
    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mcb_cmd_arb.sv
// Round-robin arbiter sharing one MCB command port between a write
// client and a read client, with a data-phase watchdog.
// Ports: wr_*/rd_* client req/addr/len/gnt/done; cmd_* MCB command
// port; busy; sticky err_timeout. Optional MCB_ARB_STATS_EN adds
// saturating wr_cmd_cnt / rd_cmd_cnt.
module mcb_cmd_arb
    import mcb_arb_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int LEN_W   = 7,
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    output logic              wr_gnt,
    input  logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_gnt,
    input  logic              rd_done,
    output logic              cmd_en,
    output logic [2:0]        cmd_instr,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [5:0]        cmd_bl,
    input  logic              cmd_full,
    output logic              busy,
    output logic              err_timeout
`ifdef MCB_ARB_STATS_EN
   ,output logic [15:0]       wr_cmd_cnt,
    output logic [15:0]       rd_cmd_cnt
`endif
);

    arb_state_e        state_q;
    owner_e            last_q;
    logic              wr_gnt_q;
    logic              rd_gnt_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [5:0]        bl_q;
    logic [2:0]        instr_q;
    logic              pick_wr;
    logic              pick_rd;
    logic              in_data;
    logic              expire;

    // On a tie the client that did not own the port last goes first.
    assign pick_wr = wr_req && (!rd_req || last_q == OWN_RD);
    assign pick_rd = rd_req && !pick_wr;

    assign in_data = (state_q == WR_DATA) || (state_q == RD_DATA);

    mcb_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (!in_data),
        .en_i     (in_data),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= OWN_RD;
            wr_gnt_q <= 1'b0;
            rd_gnt_q <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            bl_q     <= '0;
            instr_q  <= INSTR_WR;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_wr) begin
                        state_q  <= WR_DATA;
                        wr_gnt_q <= 1'b1;
                        addr_q   <= wr_addr;
                        bl_q     <= clamp_bl(32'(wr_len), MAX_LEN);
                        instr_q  <= INSTR_WR;
                    end else if (pick_rd) begin
                        state_q  <= RD_CMD;
                        rd_gnt_q <= 1'b1;
                        addr_q   <= rd_addr;
                        bl_q     <= clamp_bl(32'(rd_len), MAX_LEN);
                        instr_q  <= INSTR_RD;
                    end
                end
                WR_DATA: begin
                    if (wr_done) begin
                        state_q <= WR_CMD;
                    end else if (expire) begin
                        state_q  <= IDLE;
                        wr_gnt_q <= 1'b0;
                        err_q    <= 1'b1;
                        last_q   <= OWN_WR;
                    end
                end
                WR_CMD: begin
                    if (!cmd_full) begin
                        state_q  <= IDLE;
                        wr_gnt_q <= 1'b0;
                        last_q   <= OWN_WR;
                    end
                end
                RD_CMD: begin
                    if (!cmd_full) state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (rd_done || expire) begin
                        state_q  <= IDLE;
                        rd_gnt_q <= 1'b0;
                        last_q   <= OWN_RD;
                        if (!rd_done) err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    wr_gnt_q <= 1'b0;
                    rd_gnt_q <= 1'b0;
                end
            endcase
        end
    end

    // Strobe is gated by cmd_full in the same cycle so it can never
    // be presented while the MCB command FIFO is full.
    assign cmd_en = !cmd_full &&
                    (state_q == WR_CMD || state_q == RD_CMD);

    assign wr_gnt      = wr_gnt_q;
    assign rd_gnt      = rd_gnt_q;
    assign cmd_instr   = instr_q;
    assign cmd_addr    = addr_q;
    assign cmd_bl      = bl_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;

`ifdef MCB_ARB_STATS_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] rd_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (cmd_en) begin
            if (state_q == WR_CMD && wr_cnt_q != 16'hFFFF)
                wr_cnt_q <= wr_cnt_q + 16'd1;
            if (state_q == RD_CMD && rd_cnt_q != 16'hFFFF)
                rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign wr_cmd_cnt = wr_cnt_q;
    assign rd_cmd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_mcb_cmd_arb.sv
// Self-checking bench for mcb_cmd_arb: vector table, directed corner
// sequences and a randomized transaction-level arbitration model.
module tb_mcb_cmd_arb;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req, wr_done, rd_req, rd_done, cmd_full;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [6:0]    wr_len, rd_len;
    logic          wr_gnt, rd_gnt, cmd_en, busy, err_timeout;
    logic [2:0]    cmd_instr;
    logic [AW-1:0] cmd_addr;
    logic [5:0]    cmd_bl;
`ifdef MCB_ARB_STATS_EN
    logic [15:0]   wr_cmd_cnt, rd_cmd_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int nw    = 0;
    int nr    = 0;

    always #5 clk = ~clk;

    mcb_cmd_arb #(
        .ADDR_W (AW), .LEN_W (7), .MAX_LEN (64), .TIMEOUT (1023)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .wr_req (wr_req), .wr_addr (wr_addr), .wr_len (wr_len),
        .wr_gnt (wr_gnt), .wr_done (wr_done),
        .rd_req (rd_req), .rd_addr (rd_addr), .rd_len (rd_len),
        .rd_gnt (rd_gnt), .rd_done (rd_done),
        .cmd_en (cmd_en), .cmd_instr (cmd_instr),
        .cmd_addr (cmd_addr), .cmd_bl (cmd_bl),
        .cmd_full (cmd_full), .busy (busy),
        .err_timeout (err_timeout)
`ifdef MCB_ARB_STATS_EN
       ,.wr_cmd_cnt (wr_cmd_cnt), .rd_cmd_cnt (rd_cmd_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint got,
                       input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Spec rule: clamp to 1..64, then subtract one.
    function automatic int model_bl(input int len);
        int c;
        c = len;
        if (c < 1) c = 1;
        if (c > 64) c = 64;
        return c - 1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        wr_req = 0; rd_req = 0; wr_done = 0; rd_done = 0;
        cmd_full = 0; wr_addr = '0; rd_addr = '0;
        wr_len = '0; rd_len = '0;
        tick(); tick();
        rst_n = 1'b1;
        nw = 0; nr = 0;
    endtask

    task automatic wait_gnt(output int who);
        who = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wr_gnt || rd_gnt) break;
        end
        if (wr_gnt && rd_gnt) chk("gnt_excl", 2, 1);
        else if (wr_gnt) who = 0;
        else if (rd_gnt) who = 1;
        else chk("gnt_wait", 0, 1);
    endtask

    // Called in the first cycle of a grant; runs the client protocol.
    task automatic run_burst(input int who, input logic [AW-1:0] ea,
                             input int ebl, input int dcyc,
                             input int fcyc, input bit drop);
        chk("grant_addr", cmd_addr, ea);
        chk("grant_bl", cmd_bl, ebl);
        chk("busy", busy, 1);
        if (who == 0) begin
            chk("wr_instr", cmd_instr, 3'b000);
            chk("rd_gnt_off", rd_gnt, 0);
            if (drop) begin
                wr_req = 0; wr_addr = $urandom; wr_len = $urandom;
            end
            for (int k = 0; k < dcyc; k++) begin
                rd_done = (k == 0);
                chk("wr_data_en", cmd_en, 0);
                tick();
                rd_done = 0;
            end
            chk("wr_gnt_data", wr_gnt, 1);
            cmd_full = (fcyc > 0);
            wr_done = 1;
            tick();
            wr_done = 0;
            for (int k = 0; k < fcyc; k++) begin
                chk("wr_full_en", cmd_en, 0);
                chk("wr_full_gnt", wr_gnt, 1);
                tick();
            end
            cmd_full = 0;
            #1;
            chk("wr_cmd_en", cmd_en, 1);
            chk("wr_cmd_instr", cmd_instr, 3'b000);
            chk("wr_cmd_addr", cmd_addr, ea);
            chk("wr_cmd_bl", cmd_bl, ebl);
            tick();
            chk("wr_gnt_drop", wr_gnt, 0);
            chk("wr_en_once", cmd_en, 0);
            nw++;
        end else begin
            chk("rd_instr", cmd_instr, 3'b001);
            chk("wr_gnt_off", wr_gnt, 0);
            if (drop) begin
                rd_req = 0; rd_addr = $urandom; rd_len = $urandom;
            end
            for (int k = 0; k < fcyc; k++) begin
                cmd_full = 1;
                #1;
                chk("rd_full_en", cmd_en, 0);
                tick();
            end
            cmd_full = 0;
            #1;
            chk("rd_cmd_en", cmd_en, 1);
            chk("rd_cmd_addr", cmd_addr, ea);
            tick();
            chk("rd_en_once", cmd_en, 0);
            for (int k = 0; k < dcyc; k++) begin
                wr_done = (k == 0);
                tick();
                wr_done = 0;
            end
            chk("rd_gnt_data", rd_gnt, 1);
            chk("rd_bl_stable", cmd_bl, ebl);
            rd_done = 1;
            tick();
            rd_done = 0;
            chk("rd_gnt_drop", rd_gnt, 0);
            nr++;
        end
    endtask

    typedef struct {
        bit            rd;
        logic [AW-1:0] addr;
        logic [6:0]    len;
        int            bl;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int who, n, seen, exp_who, m_last;
        bit wp, rp;
        logic [AW-1:0] wa, ra;
        int wb, rb;

        tbl[0] = '{0, 30'h400,    7'd64,  63};
        tbl[1] = '{0, 30'h10,     7'd0,   0};
        tbl[2] = '{0, 30'h20,     7'd100, 63};
        tbl[3] = '{1, 30'h3FF00,  7'd1,   0};
        tbl[4] = '{1, 30'h1234,   7'd63,  62};
        tbl[5] = '{0, 30'h2000,   7'd65,  63};
        tbl[6] = '{1, 30'hABC0,   7'd127, 63};
        tbl[7] = '{1, 30'h5,      7'd0,   0};

        do_reset();
        chk("rst_wr_gnt", wr_gnt, 0);
        chk("rst_rd_gnt", rd_gnt, 0);
        chk("rst_cmd_en", cmd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_instr", cmd_instr, 0);
        chk("rst_addr", cmd_addr, 0);
        chk("rst_bl", cmd_bl, 0);

        // Single 64-word write, then a write with cmd_full held 5 cycles.
        wr_addr = 30'h400; wr_len = 7'd64; wr_req = 1;
        wait_gnt(who);
        chk("single_who", who, 0);
        if (who == 0) run_burst(0, 30'h400, 63, 64, 0, 1);
        wr_addr = 30'h800; wr_len = 7'd8; wr_req = 1;
        wait_gnt(who);
        chk("full_who", who, 0);
        if (who == 0) run_burst(0, 30'h800, 7, 3, 5, 1);

        rd_done = 1; wr_done = 1;
        tick();
        rd_done = 0; wr_done = 0;
        chk("idle_done_ignored", busy, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rd) begin
                rd_addr = tbl[i].addr; rd_len = tbl[i].len; rd_req = 1;
            end else begin
                wr_addr = tbl[i].addr; wr_len = tbl[i].len; wr_req = 1;
            end
            wait_gnt(who);
            chk("tbl_who", who, int'(tbl[i].rd));
            if (who >= 0)
                run_burst(who, tbl[i].addr, tbl[i].bl, 2, i % 3, 1);
        end

        // Contention from reset: both held, expect W R W R.
        do_reset();
        wr_addr = 30'h100; wr_len = 7'd4;
        rd_addr = 30'h200; rd_len = 7'd5;
        wr_req = 1; rd_req = 1;
        for (int b = 0; b < 4; b++) begin
            wait_gnt(who);
            chk("cont_order", who, b % 2);
            if (who == 0) run_burst(0, 30'h100, 3, 1, 0, 0);
            else if (who == 1) run_burst(1, 30'h200, 4, 1, 0, 0);
        end
        wr_req = 0; rd_req = 0;

        // Randomized traffic against a transaction-level model.
        do_reset();
        m_last = 1;
        wp = 0; rp = 0;
        wa = '0; ra = '0; wb = 0; rb = 0;
        for (int it = 0; it < 40; it++) begin
            if (!wp && $urandom_range(1, 0) == 1) begin
                wp = 1; wa = $urandom; wr_addr = wa;
                wr_len = 7'($urandom); wb = model_bl(int'(wr_len));
            end
            if (!rp && $urandom_range(1, 0) == 1) begin
                rp = 1; ra = $urandom; rd_addr = ra;
                rd_len = 7'($urandom); rb = model_bl(int'(rd_len));
            end
            if (!wp && !rp) begin
                wp = 1; wa = $urandom; wr_addr = wa;
                wr_len = 7'($urandom); wb = model_bl(int'(wr_len));
            end
            wr_req = wp; rd_req = rp;
            exp_who = (wp && rp) ? (1 - m_last) : (wp ? 0 : 1);
            wait_gnt(who);
            chk("rand_pick", who, exp_who);
            if (who < 0) break;
            if (who == 0)
                run_burst(0, wa, wb, $urandom_range(4, 0),
                          $urandom_range(3, 0), 1);
            else
                run_burst(1, ra, rb, $urandom_range(4, 0),
                          $urandom_range(3, 0), 1);
            if (who == 0) wp = 0; else rp = 0;
            m_last = who;
        end
        wr_req = 0; rd_req = 0;
        tick();
`ifdef MCB_ARB_STATS_EN
        chk("stat_wr", wr_cmd_cnt, nw);
        chk("stat_rd", rd_cmd_cnt, nr);
`endif

        // Reset in WR_DATA abandons the burst.
        do_reset();
        wr_addr = 30'h999; wr_len = 7'd9; wr_req = 1;
        wait_gnt(who);
        wr_req = 0;
        tick(); tick();
        wr_done = 1; rst_n = 0;
        tick();
        wr_done = 0;
        chk("mid_rst_gnt", wr_gnt, 0);
        chk("mid_rst_en", cmd_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", cmd_addr, 0);
        chk("mid_rst_bl", cmd_bl, 0);
        rst_n = 1;
        tick();
        chk("post_rst_en", cmd_en, 0);
        chk("post_rst_busy", busy, 0);

        // Read stall: watchdog fires 1023 cycles after RD_DATA entry.
        do_reset();
        rd_addr = 30'h300; rd_len = 7'd8; rd_req = 1;
        wait_gnt(who);
        chk("to_who", who, 1);
        rd_req = 0;
        tick();
        chk("to_rd_data", rd_gnt, 1);
        wr_addr = 30'h7000; wr_len = 7'd4; wr_req = 1;
        n = 0;
        while (!err_timeout && n < 1100) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 1023);
        chk("to_rd_gnt", rd_gnt, 0);
        tick();
        chk("to_wr_next", wr_gnt, 1);
        chk("to_sticky", err_timeout, 1);
        if (wr_gnt) run_burst(0, 30'h7000, 3, 1, 0, 1);
        chk("to_sticky2", err_timeout, 1);

        // rd_done on the expiry cycle wins.
        do_reset();
        chk("rst_err_clr", err_timeout, 0);
        rd_addr = 30'h44; rd_len = 7'd2; rd_req = 1;
        wait_gnt(who);
        rd_req = 0;
        tick();
        repeat (1022) tick();
        chk("edge_no_err", err_timeout, 0);
        rd_done = 1;
        tick();
        rd_done = 0;
        chk("edge_done_err", err_timeout, 0);
        chk("edge_done_gnt", rd_gnt, 0);

        // Write stall: no cmd_en, write still counts as last owner.
        wr_addr = 30'h55; wr_len = 7'd3; wr_req = 1;
        wait_gnt(who);
        chk("wto_who", who, 0);
        wr_req = 0;
        n = 0; seen = 0;
        while (!err_timeout && n < 1100) begin
            tick();
            n++;
            if (cmd_en) seen++;
        end
        chk("wto_cycles", n, 1023);
        chk("wto_no_en", seen, 0);
        chk("wto_gnt", wr_gnt, 0);
        wr_addr = 30'h66; rd_addr = 30'h77;
        wr_req = 1; rd_req = 1;
        wait_gnt(who);
        chk("wto_last_owner", who, 1);
        wr_req = 0; rd_req = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mcb_cmd_arb.md
Name: mcb_cmd_arb

Overview:
- Sequences and shares one MCB user command port between two clients: the write-burst generator and the read-back checker.
- Grants one client at a time, round-robin.
- Write grants: client fills the MCB write FIFO first, then the arbiter issues the write command.
- Read grants: the arbiter issues the read command first, then the client drains the read FIFO.
- A watchdog recovers the port if a client stalls.

Parameters:
- ADDR_W, 30, byte address width to MCB.
- LEN_W, 7, client burst-length field width.
- MAX_LEN, 64, maximum burst length in words; latched length is clamped to 1..MAX_LEN.
- TIMEOUT, 1023, data-phase watchdog limit in clk cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- wr_req  in  1  write client requests port (level, held until granted).
- wr_addr  in  ADDR_W  write burst address, sampled at grant.
- wr_len  in  LEN_W  write burst length, sampled at grant.
- wr_gnt  out  1  write client owns port.
- wr_done  in  1  one-cycle pulse: write data fully pushed to MCB FIFO.
- rd_req  in  1  read client request.
- rd_addr  in  ADDR_W  read burst address, sampled at grant.
- rd_len  in  LEN_W  read burst length, sampled at grant.
- rd_gnt  out  1  read client owns port.
- rd_done  in  1  one-cycle pulse: read data fully consumed.
- cmd_en  out  1  one-cycle MCB command strobe.
- cmd_instr  out  3  3'b000 write, 3'b001 read.
- cmd_addr  out  ADDR_W  latched burst address.
- cmd_bl  out  6  latched length minus 1.
- cmd_full  in  1  MCB command FIFO full; no cmd_en while high.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky; watchdog fired.

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; wr_gnt, rd_gnt, cmd_en, busy, err_timeout all 0; cmd_instr 0, cmd_addr 0, cmd_bl 0; last_owner = READ, so write wins the first tie. Reset mid-burst abandons the burst immediately; no cmd_en is issued.
- States:
  - IDLE: no grant. If exactly one req is high, grant that client. If both are high, grant the client that is not last_owner. On the transition, latch addr and clamp len; go to WR_DATA or RD_CMD. The grant is visible the cycle after the req is sampled.
  - WR_DATA: wr_gnt = 1, watchdog running. wr_done → WR_CMD.
  - WR_CMD: wr_gnt stays 1. On the first cycle with cmd_full = 0, pulse cmd_en for exactly 1 cycle with instr 000; then → IDLE, drop wr_gnt, last_owner = WRITE.
  - RD_CMD: rd_gnt = 1. On the first cycle with cmd_full = 0, pulse cmd_en with instr 001 → RD_DATA.
  - RD_DATA: rd_gnt = 1, watchdog running. rd_done → IDLE, drop rd_gnt, last_owner = READ.
- Handshake rules:
  - cmd_addr, cmd_bl and cmd_instr are stable from grant until the grant drops.
  - A done pulse from the non-granted client, or done outside a data state, is ignored.
- Length clamp: len = 0 → 1; len > MAX_LEN → MAX_LEN. cmd_bl = clamped − 1, so cmd_bl = 63 for MAX_LEN 64.
- Watchdog:
  - Counter clears on entry to WR_DATA or RD_DATA and increments each cycle in those states.
  - On reaching TIMEOUT: err_timeout = 1 (sticky until reset), grant dropped, → IDLE.
  - No cmd_en on write timeout; last_owner is still updated.
  - A done arriving on the same cycle as expiry wins: normal path, no error.
- No back-to-back grant to the same client while the other is requesting (strict alternation under contention). Minimum turnaround is 1 IDLE cycle between grants.

Optional Feature:
- MCB_ARB_STATS_EN defined: adds outputs wr_cmd_cnt[15:0] and rd_cmd_cnt[15:0].
  - Each increments on its cmd_en, saturates at 16'hFFFF, and resets to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package mcb_arb_pkg: state enum (IDLE, WR_DATA, WR_CMD, RD_CMD, RD_DATA); constants INSTR_WR = 3'b000, INSTR_RD = 3'b001; owner encoding.
- Sub-module mcb_arb_wdog (clear, enable, expire output, TIMEOUT parameter) is natural.

Test Plan:
- Single write: wr_req, addr 0x400, len 64; wr_done after 64 cycles → one cmd_en with instr 000, addr 0x400, bl 63; wr_gnt drops the cycle after.
- Contention: wr_req and rd_req both held high from reset → grant order W, R, W, R across 4 bursts; never two consecutive grants to the same client.
- cmd_full held high 5 cycles in WR_CMD → cmd_en asserted exactly once, on the first cycle after cmd_full falls.
- Read stall: rd_req, rd_done never pulsed, TIMEOUT = 1023 → err_timeout rises 1023 cycles after RD_DATA entry; rd_gnt drops; a pending wr_req is granted next.
- Clamp: wr_len 0 → bl 0; wr_len 100 → bl 63. rst_n low in WR_DATA → all outputs return to reset values, no cmd_en.
- With MCB_ARB_STATS_EN: 3 writes and 2 reads → wr_cmd_cnt 3, rd_cmd_cnt 2.
